// File: rtl/mem_handle_responder.sv
// mem_handle_responder
//   Memory-side responder for the mem_handle request interface. Accepts one
//   read, write or flush per handshake, bounds-checks ptr against the client
//   region, services the request on a word-addressed memory port and answers
//   with a one-cycle done pulse. A single-entry write buffer absorbs
//   non-write-through stores.
//
//   Build option: define MEM_HANDLE_WBUF_EN to build the write buffer. Without
//   it every write goes straight to memory, every read goes to memory, flush
//   completes immediately and buf_dirty stays 0.
//
// Ports
//   clock, reset_n                      clock, asynchronous active-low reset
//   region_begin, region_end, ptr       inclusive client region and target address
//   w_en, r_en, flush                   request strobes (exactly one per request)
//   write_through, read_through         buffer-bypass qualifiers
//   data_store                          write data
//   avail                               ready to accept a request (IDLE)
//   done, region_err                    completion pulse and rejection flag
//   data_load                           last read result (held between reads)
//   buf_dirty                           write buffer holds unwritten data
//   mem_req, mem_we, mem_addr, mem_wdata  memory request, held until mem_ready
//   mem_ready, mem_rvalid, mem_rdata    memory handshake and read return
module mem_handle_responder #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] region_begin,
   input  logic [ADDR_W-1:0] region_end,
   input  logic [ADDR_W-1:0] ptr,
   input  logic              w_en,
   input  logic              r_en,
   input  logic              flush,
   input  logic              write_through,
   input  logic              read_through,
   input  logic [DATA_W-1:0] data_store,
   output logic              avail,
   output logic              done,
   output logic              region_err,
   output logic [DATA_W-1:0] data_load,
   output logic              buf_dirty,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEM_HANDLE_WBUF_EN
   localparam logic WBUF_EN = 1'b1;
`else
   localparam logic WBUF_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, FLUSH, WRITE, RD_REQ, RD_WAIT, RESP} state_t;
   typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_FLUSH} op_t;

   state_t state, next_state;
   op_t    op_q, op_in;

   logic              wt_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              buf_valid;
   logic [ADDR_W-1:0] buf_addr;
   logic [DATA_W-1:0] buf_data;
   logic [DATA_W-1:0] load_q;

   logic multi, out_of_range, hit, eff_wt;
   logic accept, err_set;
   logic buf_from_in, buf_from_req, buf_inv;
   logic load_from_buf, load_from_mem;

   assign multi        = (r_en & w_en) | (r_en & flush) | (w_en & flush);
   assign out_of_range = (ptr < region_begin) || (ptr > region_end);
   assign hit          = buf_valid && (buf_addr == ptr);
   // Without the buffer every store is forced down the write-through path.
   assign eff_wt       = WBUF_EN ? write_through : 1'b1;
   assign op_in        = flush ? OP_FLUSH : (w_en ? OP_WRITE : OP_READ);

   assign avail      = (state == IDLE);
   assign done       = (state == RESP);
   assign region_err = done & err_q;
   assign data_load  = load_q;
   assign buf_dirty  = buf_valid;

   always_comb begin
      next_state    = state;
      accept        = 1'b0;
      err_set       = 1'b0;
      buf_from_in   = 1'b0;
      buf_from_req  = 1'b0;
      buf_inv       = 1'b0;
      load_from_buf = 1'b0;
      load_from_mem = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      unique case (state)
         IDLE: begin
            if (r_en | w_en | flush) begin
               accept = 1'b1;
               if (multi || (!flush && out_of_range)) begin
                  err_set    = 1'b1;
                  next_state = RESP;
               end else if (flush) begin
                  next_state = buf_valid ? FLUSH : RESP;
               end else if (w_en) begin
                  if (!eff_wt) begin
                     if (!buf_valid || hit) begin
                        buf_from_in = 1'b1;
                        next_state  = RESP;
                     end else begin
                        next_state = FLUSH;
                     end
                  end else if (hit) begin
                     // The store supersedes the buffered word, so drop it.
                     buf_inv    = 1'b1;
                     next_state = WRITE;
                  end else begin
                     next_state = buf_valid ? FLUSH : WRITE;
                  end
               end else begin
                  if (hit && !read_through) begin
                     load_from_buf = 1'b1;
                     next_state    = RESP;
                  end else if (hit) begin
                     next_state = FLUSH;
                  end else begin
                     next_state = RD_REQ;
                  end
               end
            end
         end
         FLUSH: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = buf_addr;
            mem_wdata = buf_data;
            if (mem_ready) begin
               unique case (op_q)
                  OP_READ: begin
                     buf_inv    = 1'b1;
                     next_state = RD_REQ;
                  end
                  OP_WRITE: begin
                     if (wt_q) begin
                        buf_inv    = 1'b1;
                        next_state = WRITE;
                     end else begin
                        // Evicted entry is replaced by the pending store.
                        buf_from_req = 1'b1;
                        next_state   = RESP;
                     end
                  end
                  default: begin
                     buf_inv    = 1'b1;
                     next_state = RESP;
                  end
               endcase
            end
         end
         WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            if (mem_ready) next_state = RESP;
         end
         RD_REQ: begin
            mem_req  = 1'b1;
            mem_addr = addr_q;
            if (mem_ready) next_state = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rvalid) begin
               load_from_mem = 1'b1;
               next_state    = RESP;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         op_q      <= OP_READ;
         wt_q      <= 1'b0;
         err_q     <= 1'b0;
         buf_valid <= 1'b0;
         load_q    <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            op_q  <= op_in;
            wt_q  <= eff_wt;
            err_q <= err_set;
         end
         if (buf_from_in || buf_from_req) buf_valid <= 1'b1;
         else if (buf_inv)                buf_valid <= 1'b0;
         if (load_from_buf)      load_q <= buf_data;
         else if (load_from_mem) load_q <= mem_rdata;
      end
   end

   // Address/data holding registers are qualified by state and buffer valid,
   // so they carry no reset.
   always_ff @(posedge clock) begin
      if (accept) begin
         addr_q  <= ptr;
         wdata_q <= data_store;
      end
      if (buf_from_in) begin
         buf_addr <= ptr;
         buf_data <= data_store;
      end else if (buf_from_req) begin
         buf_addr <= addr_q;
         buf_data <= wdata_q;
      end
   end

endmodule

// File: tb/tb_mem_handle_responder.sv
`timescale 1ns/1ps
module tb_mem_handle_responder;

`ifdef MEM_HANDLE_WBUF_EN
   localparam bit WBUF = 1'b1;
`else
   localparam bit WBUF = 1'b0;
`endif

   logic        clock;
   logic        reset_n;
   logic [22:0] region_begin, region_end, ptr;
   logic        w_en, r_en, flush, write_through, read_through;
   logic [31:0] data_store;
   logic        avail, done, region_err, buf_dirty;
   logic [31:0] data_load;
   logic        mem_req, mem_we;
   logic [22:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready, mem_rvalid;
   logic [31:0] mem_rdata;

   mem_handle_responder #(.ADDR_W(23), .DATA_W(32)) dut (
      .clock(clock), .reset_n(reset_n),
      .region_begin(region_begin), .region_end(region_end), .ptr(ptr),
      .w_en(w_en), .r_en(r_en), .flush(flush),
      .write_through(write_through), .read_through(read_through),
      .data_store(data_store),
      .avail(avail), .done(done), .region_err(region_err),
      .data_load(data_load), .buf_dirty(buf_dirty),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: coherent memory view + buffer occupancy
   typedef struct {
      logic        err;
      logic [31:0] load;
      logic        dirty;
      int          txn;
      int          rd;
      int          acc;
   } exp_t;
   exp_t sbq[$];

   logic [31:0] mmem [int];
   logic [31:0] bmem [int];
   bit          mvalid = 1'b0;
   logic [22:0] maddr  = '0;
   logic [31:0] mload  = '0;

   function automatic logic [31:0] init_val(input int a);
      logic [31:0] t;
      t = a;
      return (t * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   task automatic model_issue(input bit r, input bit w, input bit f, input bit wt, input bit rt,
                              input logic [22:0] p, input logic [31:0] d, input int acc);
      exp_t e;
      int   n;
      int   a;
      bit   h;
      a = int'(p);
      n = int'(r) + int'(w) + int'(f);
      e.err = 1'b0; e.txn = 0; e.rd = 0; e.acc = acc;
      if (n > 1 || (!f && (p < region_begin || p > region_end))) begin
         e.err = 1'b1;
      end else if (f) begin
         if (WBUF && mvalid) begin e.txn = 1; mvalid = 1'b0; end
      end else if (w) begin
         mmem[a] = d;
         if (WBUF && !wt) begin
            e.txn  = (mvalid && maddr != p) ? 1 : 0;
            mvalid = 1'b1;
            maddr  = p;
         end else begin
            e.txn  = 1 + ((WBUF && mvalid && maddr != p) ? 1 : 0);
            mvalid = 1'b0;
         end
      end else begin
         h     = WBUF && mvalid && (maddr == p);
         mload = mmem.exists(a) ? mmem[a] : init_val(a);
         if (h && !rt) e.txn = 0;
         else if (h) begin e.txn = 2; e.rd = 1; mvalid = 1'b0; end
         else begin e.txn = 1; e.rd = 1; end
      end
      e.load  = mload;
      e.dirty = mvalid;
      sbq.push_back(e);
   endtask

   // ---------------- memory slave
   int          stall_cnt = 0, max_stall = 0, max_rv = 0, rv_force = -1, rv_cnt = 0;
   bit          rd_act = 1'b0, prev_stall = 1'b0;
   logic [31:0] rd_q;
   int          txn_cnt = 0, rd_cnt = 0, extra_cnt = 0;
   logic [22:0] last_wa = '0;
   logic [31:0] last_wd = '0;
   logic [63:0] held;

   initial begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clock);
         mem_ready  = 1'b0;
         mem_rvalid = 1'b0;
         if (!reset_n) begin
            rd_act = 1'b0; prev_stall = 1'b0; stall_cnt = 0;
            continue;
         end
         if (prev_stall) check("mem_hold", {7'd0, mem_req, mem_we, mem_addr, mem_wdata}, held);
         prev_stall = 1'b0;
         if (rd_act) begin
            if (rv_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = rd_q; rd_act = 1'b0; end
            else begin rv_cnt--; extra_cnt++; end
         end
         if (mem_req) begin
            if (stall_cnt > 0) begin
               stall_cnt--; extra_cnt++;
               prev_stall = 1'b1;
               held = {7'd0, mem_req, mem_we, mem_addr, mem_wdata};
            end else begin
               mem_ready = 1'b1;
               txn_cnt++;
               if (mem_we) begin
                  bmem[int'(mem_addr)] = mem_wdata;
                  last_wa = mem_addr; last_wd = mem_wdata;
               end else begin
                  rd_cnt++;
                  rd_q   = bmem.exists(int'(mem_addr)) ? bmem[int'(mem_addr)] : init_val(int'(mem_addr));
                  rd_act = 1'b1;
                  rv_cnt = (rv_force >= 0) ? rv_force : int'($urandom_range(0, max_rv));
               end
               stall_cnt = (max_stall == 0) ? 0 : int'($urandom_range(0, max_stall));
            end
         end
      end
   end

   // ---------------- monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset_n && done) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
            end else begin
               e = sbq.pop_front();
               check("region_err", region_err, e.err);
               check("data_load", data_load, e.load);
               check("buf_dirty", buf_dirty, e.dirty);
               check("mem_txn", txn_cnt, e.txn);
               check("mem_reads", rd_cnt, e.rd);
               check("latency", cyc - e.acc + 1, 1 + e.txn + e.rd + extra_cnt);
            end
            txn_cnt = 0; rd_cnt = 0; extra_cnt = 0;
         end
      end
   end

   // ---------------- driver
   task automatic issue(input bit r, input bit w, input bit f, input bit wt, input bit rt,
                        input logic [22:0] p, input logic [31:0] d, input bit garbage);
      int k;
      k = 0;
      @(negedge clock);
      while (!avail && k < 300) begin @(negedge clock); k++; end
      if (!avail) begin
         checks++; errors++;
         $display("FAIL avail_timeout: got avail=0 expected 1");
         return;
      end
      r_en = r; w_en = w; flush = f; write_through = wt; read_through = rt;
      ptr = p; data_store = d;
      model_issue(r, w, f, wt, rt, p, d, cyc + 1);
      @(negedge clock);
      r_en = 1'b0; w_en = 1'b0; flush = 1'b0;
      k = 0;
      while (garbage && !avail && k < 300) begin
         r_en = 1'($urandom_range(0, 1)); w_en = 1'($urandom_range(0, 1));
         flush = 1'($urandom_range(0, 1));
         ptr = 23'($urandom); data_store = $urandom;
         @(negedge clock);
         k++;
      end
      r_en = 1'b0; w_en = 1'b0; flush = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((sbq.size() != 0 || !avail) && k < 300) begin @(negedge clock); k++; end
      if (sbq.size() != 0 || !avail) begin
         checks++; errors++;
         $display("FAIL idle_timeout: got pending=%0d expected 0", sbq.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int a;
      int kind;
      reset_n = 1'b0;
      region_begin = 23'h100; region_end = 23'h1FF; ptr = '0;
      w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
      write_through = 1'b0; read_through = 1'b0; data_store = '0;
      repeat (2) @(negedge clock);
      check("rst_avail", avail, 1);
      check("rst_done", done, 0);
      check("rst_region_err", region_err, 0);
      check("rst_data_load", data_load, 0);
      check("rst_buf_dirty", buf_dirty, 0);
      check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
      reset_n = 1'b1;

      // bounds error
      issue(1, 0, 0, 0, 0, 23'h200, 32'h0, 0);
      wait_idle();
      // buffered store then read-back
      issue(0, 1, 0, 0, 0, 23'h150, 32'hDEADBEEF, 0);
      wait_idle();
      check("store_dirty", buf_dirty, WBUF);
      issue(1, 0, 0, 0, 0, 23'h150, 32'h0, 0);
      wait_idle();
      check("readback", data_load, 32'hDEADBEEF);
      // eviction
      issue(0, 1, 0, 0, 0, 23'h151, 32'h12345678, 0);
      wait_idle();
      check("evict_addr", last_wa, WBUF ? 23'h150 : 23'h151);
      check("evict_data", last_wd, WBUF ? 32'hDEADBEEF : 32'h12345678);
      // read miss with 3 stall cycles
      bmem[32'h180] = 32'hCAFEF00D; mmem[32'h180] = 32'hCAFEF00D;
      stall_cnt = 3;
      issue(1, 0, 0, 0, 0, 23'h180, 32'h0, 0);
      wait_idle();
      check("miss_data", data_load, 32'hCAFEF00D);
      // conflicting strobes, then out-of-range flush is still legal
      issue(1, 1, 0, 0, 0, 23'h150, 32'h0, 0);
      issue(0, 0, 1, 0, 0, 23'h000, 32'h0, 0);
      wait_idle();
      check("flush_addr", last_wa, 23'h151);
      check("flush_data", last_wd, 32'h12345678);
      check("flush_dirty", buf_dirty, 0);

      // reset while waiting for read data
      rv_force = 6;
      issue(1, 0, 0, 0, 0, 23'h1A0, 32'h0, 0);
      k = 0;
      while (!rd_act && k < 50) begin @(negedge clock); k++; end
      @(negedge clock);
      check("in_rd_wait", {avail, mem_req, done}, 0);
      #2 reset_n = 1'b0;
      #1;
      check("rst_rdwait_mem_req", mem_req, 0);
      check("rst_rdwait_avail", avail, 1);
      check("rst_rdwait_done", done, 0);
      check("rst_rdwait_load", data_load, 0);
      sbq.delete(); mvalid = 1'b0; mload = '0; rv_force = -1;
      repeat (2) @(negedge clock);
      txn_cnt = 0; rd_cnt = 0; extra_cnt = 0;
      reset_n = 1'b1;
      repeat (3) @(negedge clock);

      // reset while a read request is stalled with mem_req high
      stall_cnt = 8;
      issue(1, 0, 0, 0, 0, 23'h1A4, 32'h0, 0);
      @(negedge clock);
      check("stalled_req", mem_req, 1);
      #2 reset_n = 1'b0;
      #1;
      check("rst_req_mem_req", mem_req, 0);
      check("rst_req_avail", avail, 1);
      sbq.delete(); mvalid = 1'b0; mload = '0;
      repeat (2) @(negedge clock);
      stall_cnt = 0; txn_cnt = 0; rd_cnt = 0; extra_cnt = 0;
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // randomized traffic over a small window to provoke hits and evictions
      region_begin = 23'h100; region_end = 23'h10F;
      max_stall = 2; max_rv = 2;
      for (int i = 0; i < 300; i++) begin
         kind = int'($urandom_range(0, 9));
         a    = 32'hFE + int'($urandom_range(0, 19));
         case (kind)
            0, 1, 2, 3: issue(1, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 23'(a), $urandom, 1);
            4, 5, 6, 7: issue(0, 1, 0, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 23'(a), $urandom, 1);
            8:          issue(0, 0, 1, 0, 0, 23'(a), $urandom, 1);
            default:    issue(1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0, 0, 23'(a), $urandom, 1);
         endcase
      end

      // drain the buffer and compare backing memory with the model
      max_stall = 0; max_rv = 0;
      issue(0, 0, 1, 0, 0, 23'h0, 32'h0, 0);
      wait_idle();
      check("final_dirty", buf_dirty, 0);
      foreach (mmem[ad]) begin
         check("mem_final", bmem.exists(ad) ? bmem[ad] : init_val(ad), mmem[ad]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
